mod_counter_cascade: RTL
========================

Name: mod_counter_cascade

Overview:
Parametrised successor to the single-stage modulo counter: a chain of NUM_STAGES modulo counters, cascaded through their carries and borrows. Each stage has a run-time modulus. The chain counts up or down, supports a synchronous parallel load, and gives per-stage and whole-chain wrap pulses. It is used for baud/bit/frame timing in the transmitter datapath (e.g. prescaler x bit index) and for multi-digit BCD-style counts.

Parameters:
NUM_STAGES, 2, number of cascaded stages (>=1); stage 0 is least significant
WID, 4, width of each stage's count and modulus field
DEFAULT_MOD, 10, reserved for bench/tie-off use; the RTL uses mod_value only

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
increment  input  1  count up by one (stage 0) this cycle
decrement  input  1  count down by one (stage 0) this cycle
load  input  1  synchronous parallel load of load_value
load_value  input  NUM_STAGES*WID  packed per-stage load values; stage k at [k*WID +: WID]
mod_value  input  NUM_STAGES*WID  packed per-stage moduli, same packing
count  output  NUM_STAGES*WID  packed per-stage counts, same packing
stage_wrap  output  NUM_STAGES  per-stage wrap pulse (up-wrap or down-wrap) this cycle
rolling_over  output  1  whole chain wraps upward this cycle
rolling_under  output  1  whole chain wraps downward this cycle
at_zero  output  1  all stages currently 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset. All state changes occur on posedge clk.
- Reset: all count fields go to 0. Outputs after reset: stage_wrap=0, rolling_over=0, rolling_under=0, at_zero=1.
- Priority is reset > load > step.
- Load: count <= load_value verbatim, with no clipping. Pulses are forced to 0 in the load cycle.
- Step direction:
  - increment && !decrement = up.
  - decrement && !increment = down.
  - Both set or neither set = hold, and all pulses are 0.
- Stage enable: stage 0 is enabled by step. Stage k (k>0) is enabled when stage k-1 is enabled and stage_wrap[k-1]=1.
- Up step on an enabled stage with modulus M:
  - count >= M-1 → count <= 0, stage_wrap=1. This covers out-of-range counts left by a load or a modulus change.
  - Otherwise count <= count+1.
- Down step on an enabled stage:
  - count == 0 → count <= M-1, stage_wrap=1.
  - count > M-1 (out of range) → count <= M-1, stage_wrap=0.
  - Otherwise count <= count-1.
- Degenerate moduli: M=0 and M=1 both behave as modulus 1. The stage holds 0 and wraps on every enabled step, so the carry passes straight through.
- Pulses (stage_wrap, rolling_over, rolling_under) are combinational from the current count, mod_value and step inputs, and are valid in the same cycle as the step.
  - rolling_over = up && stage_wrap[NUM_STAGES-1].
  - rolling_under = down && stage_wrap[NUM_STAGES-1].
- at_zero is combinational from the registered count only.
- Latency: count reflects a step, load or reset one cycle after the edge that samples it.
- mod_value is sampled continuously. Changing it mid-count takes effect on the next step; there is no implicit clear.
- Arithmetic: the increment uses a WID+1-bit compare so that M-1 with M=0 does not underflow (M is forced to 1 first). No stage can exceed 2^WID-1.
- Reset asserted mid-chain-wrap: reset wins, count=0, and no pulse is asserted that cycle.

Decomposition:
- Package mod_counter_pkg holds:
  - typedef dir_t enum {DIR_HOLD, DIR_UP, DIR_DOWN};
  - the function eff_mod(M), which maps 0 to 1;
  - the stage-slice localparam helpers.
- Sub-module mod_counter_stage: one WID-bit stage with inputs clk, reset, en, dir, load, load_val, mod and outputs count, wrap. The top level instantiates it in a generate loop and chains en.

Test Plan:
1. NUM_STAGES=2, WID=4, mod={6,10}; reset, then 59 up steps → count={5,9}, no rolling_over. The 60th step → rolling_over=1, stage_wrap=2'b11, count={0,0}, at_zero=1 next cycle.
2. From reset, one down step with mod={6,10} → rolling_under=1, count={5,9}. A further down step → count={5,8}, stage_wrap=2'b00.
3. Load load_value={2,14} with mod={6,10}, then one up step → stage0 wraps to 0 and stage1 becomes 3. With stage0 at 14 (out of range), a down step → stage0=9, no borrow, stage1 unchanged.
4. increment=decrement=1 for 5 cycles at count={3,4} → count unchanged, all pulses 0. Load and increment together with load_value={1,1} → count={1,1}, pulses 0.
5. mod={0,10}: every up step advances stage0 by 1 and stage1 stays 0. Stage0 9→0 with stage1=0 → rolling_over=1.
6. Reset asserted in the cycle where rolling_over would fire (count={5,9}, increment=1) → count={0,0} next cycle; the bench checks the reset-cycle pulse expectation is 0 on the registered side only.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the cascaded modulo counter.
package mod_counter_pkg;

    typedef enum logic [1:0] {DIR_HOLD, DIR_UP, DIR_DOWN} dir_t;

    // Moduli 0 and 1 both count as modulus 1.
    function automatic logic [31:0] eff_mod(input logic [31:0] m);
        return (m == 32'd0) ? 32'd1 : m;
    endfunction

    function automatic int slice_lo(input int stage, input int wid);
        return stage * wid;
    endfunction

endpackage

// File: rtl/mod_counter_stage.sv
// One WID-bit modulo counter stage; wrap is combinational and qualified by en.
module mod_counter_stage
    import mod_counter_pkg::*;
#(
    parameter int WID = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  dir_t           dir,
    input  logic           load,
    input  logic [WID-1:0] load_val,
    input  logic [WID-1:0] mod,
    output logic [WID-1:0] count,
    output logic           wrap
);

    localparam int EW = WID + 1;

    logic [WID:0] count_ext;
    logic [WID:0] last;
    logic         up_wrap;
    logic         down_wrap;
    logic         above;

    // One extra bit keeps M-1 from underflowing and out-of-range compares exact.
    assign count_ext = {1'b0, count};
    assign last      = EW'(eff_mod(32'(mod))) - EW'(1);
    assign up_wrap   = (count_ext >= last);
    assign down_wrap = (count == '0);
    assign above     = (count_ext > last);

    assign wrap = en && (((dir == DIR_UP) && up_wrap) || ((dir == DIR_DOWN) && down_wrap));

    // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            case (dir)
                DIR_UP:   count <= up_wrap ? '0 : count + WID'(1);
                DIR_DOWN: count <= (down_wrap || above) ? last[WID-1:0] : count - WID'(1);
                default:  count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mod_counter_cascade.sv
// Chain of modulo counter stages cascaded through carries/borrows, stage 0 least significant.
module mod_counter_cascade
    import mod_counter_pkg::*;
#(
    parameter int NUM_STAGES  = 2,
    parameter int WID         = 4,
    parameter int DEFAULT_MOD = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      increment,
    input  logic                      decrement,
    input  logic                      load,
    input  logic [NUM_STAGES*WID-1:0] load_value,
    input  logic [NUM_STAGES*WID-1:0] mod_value,
    output logic [NUM_STAGES*WID-1:0] count,
    output logic [NUM_STAGES-1:0]     stage_wrap,
    output logic                      rolling_over,
    output logic                      rolling_under,
    output logic                      at_zero
);

    dir_t                  dir;
    logic [NUM_STAGES-1:0] en;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dir = DIR_HOLD;
        if (increment && !decrement)      dir = DIR_UP;
        else if (decrement && !increment) dir = DIR_DOWN;
    end

    // Reset and load suppress the step, which also silences every pulse that cycle.
    assign en[0] = !reset && !load && (dir != DIR_HOLD);

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LO = slice_lo(k, WID);

        if (k > 0) begin : g_chain
            assign en[k] = en[k-1] && stage_wrap[k-1];
        end

        mod_counter_stage #(.WID(WID)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .en       (en[k]),
            .dir      (dir),
            .load     (load),
            .load_val (load_value[LO +: WID]),
            .mod      (mod_value[LO +: WID]),
            .count    (count[LO +: WID]),
            .wrap     (stage_wrap[k])
        );
    end

    assign rolling_over  = (dir == DIR_UP)   && stage_wrap[NUM_STAGES-1];
    assign rolling_under = (dir == DIR_DOWN) && stage_wrap[NUM_STAGES-1];
    assign at_zero       = (count == '0);

endmodule
